// File: rtl/comparator_mc_pkg.sv
// Shared types, defaults and the compare primitive for the multi-channel comparator.
package comparator_mc_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_NUM_CH     = 4;
  localparam int DEFAULT_CNT_WIDTH  = 16;

  // Operands are widened to this many bits before comparing, so one function
  // serves every DATA_WIDTH up to 64.
  localparam int CMP_WIDTH = 64;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } cmp_result_t;

  // Callers must sign-extend (signed mode) or zero-extend (unsigned mode)
  // the operands to CMP_WIDTH; the widened compare then matches the narrow one.
  function automatic cmp_result_t cmp_fn(input logic [CMP_WIDTH-1:0] a,
                                         input logic [CMP_WIDTH-1:0] b,
                                         input logic                 signed_mode);
    cmp_result_t r;
    logic        a_less;
    if (signed_mode) a_less = ($signed(a) < $signed(b));
    else             a_less = (a < b);
    r.eq = (a == b);
    r.lt = a_less;
    r.gt = !r.eq && !a_less;
    return r;
  endfunction

endpackage

// File: rtl/comparator_mc_lane.sv
// One channel: combinational compare of the stage-1 operands plus a
// saturating counter of delivered equal results.
module comparator_mc_lane
  import comparator_mc_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  signed_mode,
  output cmp_result_t           result,
  input  logic                  count_inc,
  input  logic                  count_clear,
  output logic [CNT_WIDTH-1:0]  eq_count
);

  logic [CMP_WIDTH-1:0] a_ext;
  logic [CMP_WIDTH-1:0] b_ext;
  logic [CNT_WIDTH-1:0] count_reg;

  // Widen operands according to the beat's mode, then compare.
  always_comb begin
    if (signed_mode) begin
      a_ext = CMP_WIDTH'($signed(a));
      b_ext = CMP_WIDTH'($signed(b));
    end else begin
      a_ext = CMP_WIDTH'(a);
      b_ext = CMP_WIDTH'(b);
    end
    result = cmp_fn(a_ext, b_ext, signed_mode);
  end

  // Equal counter: clear beats a same-cycle increment; holds at all-ones.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (count_clear) begin
      count_reg <= '0;
    end else if (count_inc && (count_reg != {CNT_WIDTH{1'b1}})) begin
      count_reg <= count_reg + CNT_WIDTH'(1);
    end
  end

  assign eq_count = count_reg;

endmodule

// File: rtl/comparator_mc_pipe.sv
// Multi-channel signed/unsigned comparator with a 2-stage valid/ready
// pipeline (operand register, result register) and per-channel equal counters.
module comparator_mc_pipe
  import comparator_mc_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_CH     = DEFAULT_NUM_CH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0] a_data,
  input  logic [NUM_CH*DATA_WIDTH-1:0] b_data,
  input  logic                         signed_mode,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_CH-1:0]            gt,
  output logic [NUM_CH-1:0]            eq,
  output logic [NUM_CH-1:0]            lt,
  input  logic                         count_clear,
  output logic [NUM_CH*CNT_WIDTH-1:0]  eq_count
);

  logic                         s1_valid_reg;
  logic [NUM_CH*DATA_WIDTH-1:0] s1_a_reg;
  logic [NUM_CH*DATA_WIDTH-1:0] s1_b_reg;
  logic                         s1_signed_reg;
  logic                         s2_valid_reg;
  logic [NUM_CH-1:0]            gt_reg, eq_reg, lt_reg;
  logic [NUM_CH-1:0]            gt_next, eq_next, lt_next;
  logic                         s1_advance;
  logic                         in_accept;
  logic                         out_deliver;

  // Handshake control; in_ready is held low while reset is asserted.
  always_comb begin
    s1_advance  = s1_valid_reg && (!s2_valid_reg || out_ready);
    in_ready    = reset && (!s1_valid_reg || s1_advance);
    in_accept   = in_valid && in_ready;
    out_deliver = s2_valid_reg && out_ready;
  end

  // Stage 1: capture operands and mode on an input handshake.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid_reg  <= 1'b0;
      s1_a_reg      <= '0;
      s1_b_reg      <= '0;
      s1_signed_reg <= 1'b0;
    end else if (in_accept) begin
      s1_valid_reg  <= 1'b1;
      s1_a_reg      <= a_data;
      s1_b_reg      <= b_data;
      s1_signed_reg <= signed_mode;
    end else if (s1_advance) begin
      s1_valid_reg  <= 1'b0;
    end
  end

  // Stage 2: register compare results; hold them while the sink stalls.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s2_valid_reg <= 1'b0;
      gt_reg       <= '0;
      eq_reg       <= '0;
      lt_reg       <= '0;
    end else if (s1_advance) begin
      s2_valid_reg <= 1'b1;
      gt_reg       <= gt_next;
      eq_reg       <= eq_next;
      lt_reg       <= lt_next;
    end else if (out_deliver) begin
      s2_valid_reg <= 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_lane
      cmp_result_t lane_result;

      comparator_mc_lane #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
      ) u_lane (
        .clock       (clock),
        .reset       (reset),
        .a           (s1_a_reg[gi*DATA_WIDTH +: DATA_WIDTH]),
        .b           (s1_b_reg[gi*DATA_WIDTH +: DATA_WIDTH]),
        .signed_mode (s1_signed_reg),
        .result      (lane_result),
        .count_inc   (out_deliver && eq_reg[gi]),
        .count_clear (count_clear),
        .eq_count    (eq_count[gi*CNT_WIDTH +: CNT_WIDTH])
      );

      assign gt_next[gi] = lane_result.gt;
      assign eq_next[gi] = lane_result.eq;
      assign lt_next[gi] = lane_result.lt;
    end
  endgenerate

  assign out_valid = s2_valid_reg;
  assign gt        = gt_reg;
  assign eq        = eq_reg;
  assign lt        = lt_reg;

endmodule
